clint_multi: RTL and testbench

Parametrised core-local interruptor: one shared 64-bit mtime, per-hart mtimecmp and msip registers for NrHarts harts. It is register-mapped on a simple 32-bit request/response bus and generates registered timer interrupts and inter-processor interrupts. New over the fixed two-hart version:
- configurable hart count and RTC synchroniser depth;
- selectable tick source (RTC rising edge or core clock);
- programmable prescaler;
- timer enable;
- unmapped-address error response.

---
 rtl/clint_multi.sv | 245 ++++++++++++++++++++++++
 tb/tb_clint_multi.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clint_multi.sv
// clint_multi: core-local interruptor with one shared mtime and per-hart
// mtimecmp/msip, mapped on a 32-bit request/response bus.
module clint_multi #(
    parameter int unsigned NrHarts       = 2,
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned PrescaleWidth = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [15:0]        req_addr_i,
    input  logic [31:0]        req_wdata_i,
    input  logic [3:0]         req_wstrb_i,
    output logic               rsp_valid_o,
    output logic [31:0]        rsp_rdata_o,
    output logic               rsp_error_o,
    input  logic               rtc_i,
    output logic [NrHarts-1:0] timer_irq_o,
    output logic [NrHarts-1:0] ipi_o
);

    localparam logic [13:0] CtrlWord    = 14'h2FFC;
    localparam logic [13:0] MtimeLoWord = 14'h2FFE;
    localparam logic [13:0] MtimeHiWord = 14'h2FFF;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [63:0]               mtime_q, mtime_d;
    logic [NrHarts-1:0][63:0]  mtimecmp_q, mtimecmp_d;
    logic [NrHarts-1:0]        msip_q, msip_d;
    logic                      en_q, en_d;
    logic                      src_q, src_d;
    logic [PrescaleWidth-1:0]  div_q, div_d;
    logic [PrescaleWidth-1:0]  cnt_q, cnt_d;
    logic [SyncStages-1:0]     sync_q;
    logic                      edge_q;
    logic [NrHarts-1:0]        irq_q, irq_d;
    logic                      rsp_valid_q;
    logic [31:0]               rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_error_q, rsp_error_d;

    logic [13:0]        word_addr;
    logic               msip_region;
    logic               cmp_region;
    logic               cmp_hi;
    logic               ctrl_hit;
    logic               lo_hit;
    logic               hi_hit;
    logic               mapped;
    logic               wr_en;
    logic               rd_en;
    logic [NrHarts-1:0] msip_sel;
    logic [NrHarts-1:0] cmp_sel;
    logic [31:0]        ctrl_rd;
    logic               rtc_rise;
    logic               src_pulse;
    logic               tick;
    logic [31:0]        lo_next;
    logic [31:0]        hi_next;
    logic               carry;
    logic               unused_addr;

    assign unused_addr = ^req_addr_i[1:0];

    assign word_addr   = req_addr_i[15:2];
    assign msip_region = (req_addr_i[15:14] == 2'b00);
    assign cmp_region  = (req_addr_i[15:14] == 2'b01);
    assign cmp_hi      = req_addr_i[2];
    assign ctrl_hit    = (word_addr == CtrlWord);
    assign lo_hit      = (word_addr == MtimeLoWord);
    assign hi_hit      = (word_addr == MtimeHiWord);

    always_comb begin
        for (int h = 0; h < NrHarts; h++) begin
            msip_sel[h] = msip_region && (req_addr_i[13:2] == 12'(h));
            cmp_sel[h]  = cmp_region && (req_addr_i[13:3] == 11'(h));
        end
    end

    assign mapped = (|msip_sel) | (|cmp_sel) | ctrl_hit | lo_hit | hi_hit;
    assign wr_en  = req_valid_i & req_write_i & mapped;
    assign rd_en  = req_valid_i & ~req_write_i & mapped;

    always_comb begin
        ctrl_rd                      = '0;
        ctrl_rd[0]                   = en_q;
        ctrl_rd[1]                   = src_q;
        ctrl_rd[8 +: PrescaleWidth]  = div_q;
    end

    // Rising edge of the synchronised RTC, one edge flop behind the chain.
    assign rtc_rise  = sync_q[SyncStages-1] & ~edge_q;
    assign src_pulse = src_q | rtc_rise;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        en_d  = en_q;
        src_d = src_q;
        div_d = div_q;
        if (src_pulse && en_q) begin
            if (cnt_q == div_q) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PrescaleWidth'(1);
            end
        end
        if (wr_en && ctrl_hit) begin
            cnt_d = '0;
            if (req_wstrb_i[0]) begin
                en_d  = req_wdata_i[0];
                src_d = req_wdata_i[1];
            end
            for (int i = 0; i < PrescaleWidth; i++) begin
                if (req_wstrb_i[(8+i)/8]) begin
                    div_d[i] = req_wdata_i[8+i];
                end
            end
        end
    end

    // A write to either word cuts the tick carry across the word boundary.
    always_comb begin
        carry   = tick & (&mtime_q[31:0]);
        lo_next = tick ? (mtime_q[31:0] + 32'd1) : mtime_q[31:0];
        hi_next = mtime_q[63:32] + {31'd0, carry};
        mtime_d = {hi_next, lo_next};
        if (wr_en && lo_hit) begin
            mtime_d[31:0]  = merge_bytes(lo_next, req_wdata_i, req_wstrb_i);
            mtime_d[63:32] = mtime_q[63:32];
        end
        if (wr_en && hi_hit) begin
            mtime_d[63:32] = merge_bytes(mtime_q[63:32], req_wdata_i,
                                         req_wstrb_i);
        end
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        for (int h = 0; h < NrHarts; h++) begin
            if (wr_en && msip_sel[h] && req_wstrb_i[0]) begin
                msip_d[h] = req_wdata_i[0];
            end
            if (wr_en && cmp_sel[h]) begin
                if (cmp_hi) begin
                    mtimecmp_d[h][63:32] = merge_bytes(mtimecmp_q[h][63:32],
                                                       req_wdata_i,
                                                       req_wstrb_i);
                end else begin
                    mtimecmp_d[h][31:0] = merge_bytes(mtimecmp_q[h][31:0],
                                                      req_wdata_i,
                                                      req_wstrb_i);
                end
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NrHarts; h++) begin
            irq_d[h] = (mtime_q >= mtimecmp_q[h]);
        end
    end

    always_comb begin
        rsp_rdata_d = '0;
        rsp_error_d = req_valid_i & ~mapped;
        if (rd_en) begin
            for (int h = 0; h < NrHarts; h++) begin
                if (msip_sel[h]) begin
                    rsp_rdata_d = {31'd0, msip_q[h]};
                end
                if (cmp_sel[h]) begin
                    rsp_rdata_d = cmp_hi ? mtimecmp_q[h][63:32]
                                         : mtimecmp_q[h][31:0];
                end
            end
            if (ctrl_hit) begin
                rsp_rdata_d = ctrl_rd;
            end
            if (lo_hit) begin
                rsp_rdata_d = mtime_q[31:0];
            end
            if (hi_hit) begin
                rsp_rdata_d = mtime_q[63:32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= '0;
            en_q        <= 1'b1;
            src_q       <= 1'b0;
            div_q       <= '0;
            cnt_q       <= '0;
            sync_q      <= '0;
            edge_q      <= 1'b0;
            irq_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            en_q        <= en_d;
            src_q       <= src_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[SyncStages-2:0], rtc_i};
            edge_q      <= sync_q[SyncStages-1];
            irq_q       <= irq_d;
            rsp_valid_q <= req_valid_i;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign req_ready_o = 1'b1;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_error_o = rsp_error_q;
    assign timer_irq_o = irq_q;
    assign ipi_o       = msip_q;

endmodule

// File: tb/tb_clint_multi.sv
// tb_clint_multi: directed bench for clint_multi with a response scoreboard.
// Expected bus responses are queued at acceptance and compared one cycle later.
module tb_clint_multi;

    localparam int NH = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_write_i;
    logic [15:0]   req_addr_i;
    logic [31:0]   req_wdata_i;
    logic [3:0]    req_wstrb_i;
    logic          rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_error_o;
    logic          rtc_i;
    logic [NH-1:0] timer_irq_o;
    logic [NH-1:0] ipi_o;

    clint_multi #(
        .NrHarts(NH),
        .SyncStages(2),
        .PrescaleWidth(8)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_write_i(req_write_i),
        .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .req_wstrb_i(req_wstrb_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_error_o(rsp_error_o),
        .rtc_i(rtc_i),
        .timer_irq_o(timer_irq_o),
        .ipi_o(ipi_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e_q;
    int   errors = 0;
    int   checks = 0;
    logic rtc_nxt = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (sb.size() != 0) begin
            e_q = sb.pop_front();
            chk("rsp_valid", 64'(rsp_valid_o), 64'(1));
            chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e_q.rdata));
            chk("rsp_error", 64'(rsp_error_o), 64'(e_q.err));
        end else if (rsp_valid_o !== 1'b0) begin
            chk("rsp_spurious", 64'(rsp_valid_o), 64'(0));
        end
    end

    task automatic req(input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic ee,
                       input logic push);
        exp_t e;
        @(negedge clk_i);
        rtc_i       = rtc_nxt;
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_wdata_i = d;
        req_wstrb_i = s;
        @(posedge clk_i);
        #1;
        e.rdata = er;
        e.err   = ee;
        if (push) sb.push_back(e);
        req_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic ee);
        req(1'b1, a, d, s, 32'd0, ee, 1'b1);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] er,
                      input logic ee);
        req(1'b0, a, 32'd0, 4'h0, ee ? 32'd0 : er, ee, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_t4;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_wstrb_i = '0;
        rtc_i       = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("reset_rsp_rdata", 64'(rsp_rdata_o), 64'(0));
        chk("reset_irq", 64'(timer_irq_o), 64'(0));
        chk("reset_ipi", 64'(ipi_o), 64'(0));
        chk("req_ready", 64'(req_ready_o), 64'(1));
        rst_ni = 1'b1;

        // reset register values
        rd(16'hBFF8, 32'h0000_0000, 1'b0);
        rd(16'h4000, 32'hFFFF_FFFF, 1'b0);
        rd(16'h4004, 32'hFFFF_FFFF, 1'b0);
        rd(16'hBFF0, 32'h0000_0001, 1'b0);

        // prescaler: DIV=3 on the core clock, one tick per 4 cycles
        wr(16'hBFF0, 32'h0000_0302, 4'hF, 1'b0);
        wr(16'hBFF0, 32'h0000_0303, 4'hF, 1'b0);
        for (int k = 2; k < 10; k++) begin
            rd(16'hBFF8, 32'((k - 2) / 4), 1'b0);
        end
        wr(16'hBFF0, 32'h0000_0302, 4'hF, 1'b0);
        for (int k = 11; k < 15; k++) begin
            rd(16'hBFF8, 32'd2, 1'b0);
        end
        rd(16'hBFF0, 32'h0000_0302, 1'b0);

        // timer interrupt for hart 1
        wr(16'hBFF8, 32'd0, 4'hF, 1'b0);
        wr(16'h4008, 32'h0000_0010, 4'hF, 1'b0);
        wr(16'h400C, 32'h0000_0000, 4'hF, 1'b0);
        wr(16'hBFF0, 32'h0000_0003, 4'hF, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk_i);
            #1;
            chk("irq1_rise", 64'(timer_irq_o[1]), 64'(n >= 17));
        end
        chk("irq0_low", 64'(timer_irq_o[0]), 64'(0));
        wr(16'h4008, 32'h0000_0020, 4'hF, 1'b0);
        chk("irq1_hold", 64'(timer_irq_o[1]), 64'(1));
        @(posedge clk_i);
        #1;
        chk("irq1_fall", 64'(timer_irq_o[1]), 64'(0));

        // RTC source, 8-cycle period, rising edges at k = 0, 8, 16, 24
        wr(16'hBFF0, 32'h0000_0001, 4'hF, 1'b0);
        wr(16'hBFF8, 32'd0, 4'hF, 1'b0);
        for (int k = 0; k < 32; k++) begin
            rtc_nxt = ((k % 8) < 4);
            exp_t4  = int'(k >= 3) + int'(k >= 11) + int'(k >= 19)
                    + int'(k >= 27);
            rd(16'hBFF8, 32'(exp_t4), 1'b0);
        end
        rtc_nxt = 1'b0;

        // carry handling around the word boundary
        wr(16'hBFF0, 32'h0000_0002, 4'hF, 1'b0);
        wr(16'hBFFC, 32'h0000_0000, 4'hF, 1'b0);
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0);
        wr(16'hBFF0, 32'h0000_0003, 4'hF, 1'b0);
        wr(16'hBFF8, 32'h0000_0005, 4'hF, 1'b0);
        rd(16'hBFF8, 32'h0000_0005, 1'b0);
        rd(16'hBFFC, 32'h0000_0000, 1'b0);
        wr(16'hBFF0, 32'h0000_0002, 4'hF, 1'b0);
        rd(16'hBFF8, 32'h0000_0008, 1'b0);
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0);
        wr(16'hBFF0, 32'h0000_0003, 4'hF, 1'b0);
        wr(16'hBFF0, 32'h0000_0002, 4'hF, 1'b0);
        rd(16'hBFF8, 32'h0000_0000, 1'b0);
        rd(16'hBFFC, 32'h0000_0001, 1'b0);

        // MSIP, strobes and error responses
        wr(16'h0000, 32'h0000_0001, 4'h1, 1'b0);
        chk("ipi0_set", 64'(ipi_o), 64'(2'b01));
        wr(16'h0000, 32'h0000_0000, 4'h2, 1'b0);
        chk("ipi0_strb", 64'(ipi_o), 64'(2'b01));
        wr(16'h0008, 32'h0000_0001, 4'hF, 1'b1);
        chk("ipi_err_wr", 64'(ipi_o), 64'(2'b01));
        rd(16'h0008, 32'd0, 1'b1);
        rd(16'h0000, 32'h0000_0001, 1'b0);
        wr(16'h0004, 32'hFFFF_FFFF, 4'hF, 1'b0);
        chk("ipi1_set", 64'(ipi_o), 64'(2'b11));
        rd(16'h0004, 32'h0000_0001, 1'b0);
        wr(16'h4010, 32'h0000_0000, 4'hF, 1'b1);
        rd(16'h4000, 32'hFFFF_FFFF, 1'b0);
        rd(16'h8000, 32'd0, 1'b1);
        rd(16'hBFF4, 32'd0, 1'b1);
        wr(16'h4004, 32'h0000_AB00, 4'h2, 1'b0);
        rd(16'h4004, 32'hFFFF_ABFF, 1'b0);
        wr(16'hBFF0, 32'hFFFF_FFFF, 4'h2, 1'b0);
        rd(16'hBFF0, 32'h0000_FF02, 1'b0);

        // mid-operation reset drops the in-flight response
        wr(16'h400C, 32'h0000_0000, 4'hF, 1'b0);
        @(posedge clk_i);
        #1;
        chk("irq_pre_reset", 64'(timer_irq_o), 64'(2'b10));
        req(1'b1, 16'h0000, 32'd0, 4'hF, 32'd0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("rst_rsp_drop", 64'(rsp_valid_o), 64'(0));
        chk("rst_ipi", 64'(ipi_o), 64'(0));
        chk("rst_irq", 64'(timer_irq_o), 64'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        rd(16'hBFFC, 32'h0000_0000, 1'b0);
        rd(16'h400C, 32'hFFFF_FFFF, 1'b0);
        rd(16'hBFF0, 32'h0000_0001, 1'b0);
        rd(16'h0004, 32'h0000_0000, 1'b0);

        repeat (2) @(negedge clk_i);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
